// File: rtl/score_scan_ctrl.sv
// Score registers for two players plus a 4-digit multiplexed scan of the shared decoder.
// Optional macro LEADING_ZERO_BLANK_EN blanks tens digits that are zero.
module score_scan_ctrl #(
  parameter int WIN_SCORE   = 21,
  parameter int DWELL_TICKS = 4
) (
  input  logic       clk,
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       clear_scores,
  output logic [4:0] p1_score,
  output logic [4:0] p2_score,
  output logic       game_over,
  output logic [4:0] digit_value,
  output logic [3:0] digit_an
);

  localparam logic [4:0] WIN        = 5'(WIN_SCORE);
  localparam logic [3:0] DWELL_LAST = 4'(DWELL_TICKS - 1);
  localparam logic [4:0] BLANK      = 5'h1F;

  typedef enum logic [1:0] {
    S_P1T = 2'd0,
    S_P1U = 2'd1,
    S_P2T = 2'd2,
    S_P2U = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] dwell;
  logic [4:0] snap_p1;
  logic [4:0] snap_p2;

  logic [4:0] p1_nxt;
  logic [4:0] p2_nxt;
  logic       advance;
  logic [4:0] sel_score;
  logic [4:0] tens;
  logic [4:0] units;
  logic [4:0] val_cur;
  logic [3:0] an_cur;

  function automatic logic [4:0] tens_of(input logic [4:0] s);
    if (s >= 5'd30)      return 5'd3;
    else if (s >= 5'd20) return 5'd2;
    else if (s >= 5'd10) return 5'd1;
    else                 return 5'd0;
  endfunction

  always_comb begin
    p1_nxt = p1_score;
    p2_nxt = p2_score;
    if (clear_scores) begin
      p1_nxt = 5'd0;
      p2_nxt = 5'd0;
    end else if (!game_over) begin
      if (point_p1 && p1_score != WIN) p1_nxt = p1_score + 5'd1;
      if (point_p2 && p2_score != WIN) p2_nxt = p2_score + 5'd1;
    end
  end

  assign advance = clk_1ms && (dwell == DWELL_LAST);

  always_comb begin
    sel_score = (state == S_P1T || state == S_P1U) ? snap_p1 : snap_p2;
    tens      = tens_of(sel_score);
    units     = sel_score - tens * 5'd10;
    val_cur   = units;
    an_cur    = 4'b1111;
    unique case (state)
      S_P1T: an_cur = 4'b0111;
      S_P1U: an_cur = 4'b1011;
      S_P2T: an_cur = 4'b1101;
      S_P2U: an_cur = 4'b1110;
    endcase
    if (state == S_P1T || state == S_P2T) begin
`ifdef LEADING_ZERO_BLANK_EN
      val_cur = (tens == 5'd0) ? BLANK : tens;
`else
      val_cur = tens;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      p1_score    <= 5'd0;
      p2_score    <= 5'd0;
      game_over   <= 1'b0;
      state       <= S_P1T;
      dwell       <= 4'd0;
      snap_p1     <= 5'd0;
      snap_p2     <= 5'd0;
      digit_value <= BLANK;
      digit_an    <= 4'b1111;
    end else begin
      p1_score  <= p1_nxt;
      p2_score  <= p2_nxt;
      game_over <= (p1_nxt == WIN) || (p2_nxt == WIN);
      if (advance) begin
        // one dark cycle on every digit change avoids ghosting
        state       <= state_t'(state + 2'd1);
        dwell       <= 4'd0;
        digit_value <= BLANK;
        digit_an    <= 4'b1111;
        if (state == S_P2U) begin
          snap_p1 <= p1_score;
          snap_p2 <= p2_score;
        end
      end else begin
        if (clk_1ms) dwell <= dwell + 4'd1;
        digit_value <= val_cur;
        digit_an    <= an_cur;
      end
    end
  end

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Self-checking bench for score_scan_ctrl: score vector table plus scan-frame scoreboard.
// Honours LEADING_ZERO_BLANK_EN when computing expected tens digits.
module tb_score_scan_ctrl;

  logic       clk = 1'b0;
  logic       clk_1ms = 1'b0;
  logic       reset = 1'b0;
  logic       point_p1 = 1'b0;
  logic       point_p2 = 1'b0;
  logic       clear_scores = 1'b0;
  logic [4:0] p1_score;
  logic [4:0] p2_score;
  logic       game_over;
  logic [4:0] digit_value;
  logic [3:0] digit_an;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [4:0] Z = 5'h1F;
`else
  localparam logic [4:0] Z = 5'h00;
`endif

  typedef struct {
    logic       p1;
    logic       p2;
    logic       clr;
    logic [4:0] e1;
    logic [4:0] e2;
    logic       ego;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [4:0] val;
  } dig_t;

  dig_t dig_q[$];
  vec_t vec_q[$];

  score_scan_ctrl #(.WIN_SCORE(21), .DWELL_TICKS(4)) dut (
    .clk(clk),
    .clk_1ms(clk_1ms),
    .reset(reset),
    .point_p1(point_p1),
    .point_p2(point_p2),
    .clear_scores(clear_scores),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .game_over(game_over),
    .digit_value(digit_value),
    .digit_an(digit_an)
  );

  always #5 clk = ~clk;

  // 1 ms tick every 10 clocks
  initial begin
    forever begin
      repeat (9) @(posedge clk);
      #1 clk_1ms = 1'b1;
      @(posedge clk);
      #1 clk_1ms = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic a, input logic b, input logic c,
                       input logic [4:0] e1, input logic [4:0] e2,
                       input logic ego);
    vec_t v;
    point_p1 = a;
    point_p2 = b;
    clear_scores = c;
    vec_q.push_back('{a, b, c, e1, e2, ego});
    step();
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    clear_scores = 1'b0;
    v = vec_q.pop_front();
    check("p1_score", int'(p1_score), int'(v.e1));
    check("p2_score", int'(p2_score), int'(v.e2));
    check("game_over", int'(game_over), int'(v.ego));
  endtask

  task automatic wait_an(input logic [3:0] target);
    int k;
    k = 0;
    while (digit_an != target && k < 400) begin
      step();
      k++;
    end
    if (digit_an != target) check("wait_an_timeout", int'(digit_an), int'(target));
  endtask

  task automatic drain_digits(input string name);
    dig_t d;
    while (dig_q.size() > 0) begin
      d = dig_q.pop_front();
      wait_an(d.an);
      check(name, int'(digit_value), int'(d.val));
    end
  endtask

  task automatic push_frame(input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [4:0] d);
    dig_q.push_back('{4'b0111, a});
    dig_q.push_back('{4'b1011, b});
    dig_q.push_back('{4'b1101, c});
    dig_q.push_back('{4'b1110, d});
  endtask

  vec_t tbl[5];
  int lit;
  int blank;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 5'd1, 5'd1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 5'd2, 5'd2, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 5'd2, 5'd2, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0};

    // T1 reset
    repeat (3) step();
    check("rst_p1", int'(p1_score), 0);
    check("rst_p2", int'(p2_score), 0);
    check("rst_go", int'(game_over), 0);
    check("rst_an", int'(digit_an), 4'hF);
    check("rst_val", int'(digit_value), 5'h1F);
    reset = 1'b1;
    check("rst_exit_an", int'(digit_an), 4'hF);
    step();
    check("p1t_lit_an", int'(digit_an), 4'b0111);
    check("p1t_lit_val", int'(digit_value), int'(Z));

    // score vector table
    for (int i = 0; i < 5; i++)
      apply(tbl[i].p1, tbl[i].p2, tbl[i].clr, tbl[i].e1, tbl[i].e2, tbl[i].ego);

    // T2 7 and 12, two points together
    for (int i = 1; i <= 5; i++) apply(1'b1, 1'b0, 1'b0, 5'(i), 5'd0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 5'd6, 5'd1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 5'd7, 5'd2, 1'b0);
    for (int i = 3; i <= 12; i++) apply(1'b0, 1'b1, 1'b0, 5'd7, 5'(i), 1'b0);
    wait_an(4'b1110);
    push_frame(Z, 5'd7, 5'd1, 5'd2);
    drain_digits("t2_frame");

    // T4 dwell timing and dark cycle
    wait_an(4'b1110);
    wait_an(4'b0111);
    lit = 0;
    while (digit_an == 4'b0111 && lit < 100) begin
      step();
      lit++;
    end
    check("t4_lit_len", lit, 39);
    blank = 0;
    while (digit_an == 4'b1111 && blank < 100) begin
      step();
      blank++;
    end
    check("t4_dark_len", blank, 1);
    check("t4_next_an", int'(digit_an), 4'b1011);

    // T3 saturation and game over
    apply(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
    for (int i = 1; i <= 25; i++)
      apply(1'b1, 1'b0, 1'b0, (i > 21) ? 5'd21 : 5'(i), 5'd0, i >= 21);
    apply(1'b0, 1'b1, 1'b0, 5'd21, 5'd0, 1'b1);
    apply(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);

    // T5 change during P1U shows next frame only
    for (int i = 1; i <= 3; i++) apply(1'b1, 1'b1, 1'b0, 5'(i), 5'(i), 1'b0);
    apply(1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 1'b0);
    wait_an(4'b1110);
    push_frame(Z, 5'd3, Z, 5'd4);
    drain_digits("t5_pre");
    wait_an(4'b1011);
    apply(1'b0, 1'b1, 1'b0, 5'd3, 5'd5, 1'b0);
    dig_q.push_back('{4'b1101, Z});
    dig_q.push_back('{4'b1110, 5'd4});
    push_frame(Z, 5'd3, Z, 5'd5);
    drain_digits("t5_frame");

    // T6 reset during P2T
    wait_an(4'b1101);
    reset = 1'b0;
    step();
    check("t6_an", int'(digit_an), 4'hF);
    check("t6_val", int'(digit_value), 5'h1F);
    check("t6_p2", int'(p2_score), 0);
    reset = 1'b1;
    step();
    check("t6_p1t_an", int'(digit_an), 4'b0111);
    check("t6_p1t_val", int'(digit_value), int'(Z));
    lit = 0;
    while (digit_an == 4'b0111 && lit < 100) begin
      step();
      lit++;
    end
    check("t6_dwell_restart", int'(lit >= 31 && lit <= 40), 1);
    wait_an(4'b1011);
    check("t6_p1u_val", int'(digit_value), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
